// File: rtl/smg_scan_driver.sv
// Multiplexed common-anode 7-segment scan driver with frame-synchronised shadow
// registers, leading-zero suppression, per-digit blink and PWM brightness.
module smg_scan_driver #(
  parameter int N_DIGITS     = 4,
  parameter int CLK_DIV      = 100000,
  parameter int BR_W         = 3,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*N_DIGITS-1:0] data,
  input  logic [N_DIGITS-1:0]   dp,
  input  logic [N_DIGITS-1:0]   blink_mask,
  input  logic                  lz_en,
  input  logic [BR_W-1:0]       brightness,
  input  logic                  load,
  output logic [N_DIGITS-1:0]   sm_wei,
  output logic [7:0]            sm_duan,
  output logic                  frame_done
);

  localparam int CW   = $clog2(CLK_DIV);
  localparam int IW   = $clog2(N_DIGITS);
  localparam int FW   = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int STEP = CLK_DIV / (2 ** BR_W);

  localparam logic [CW-1:0]       CNT_MAX = CW'(CLK_DIV - 1);
  localparam logic [IW-1:0]       IDX_MAX = IW'(N_DIGITS - 1);
  localparam logic [FW-1:0]       FR_MAX  = FW'(BLINK_FRAMES - 1);
  localparam logic [N_DIGITS-1:0] ONE     = N_DIGITS'(1);

  typedef struct packed {
    logic [4*N_DIGITS-1:0] data;
    logic [N_DIGITS-1:0]   dp;
    logic [N_DIGITS-1:0]   blink;
  } disp_t;

  logic [CW-1:0] cnt;
  logic [IW-1:0] idx;
  logic [FW-1:0] fcnt;
  logic          phase;
  logic          pend;
  disp_t         pend_r, act_r, in_s;
  logic          tick, boundary, lit;
  logic [31:0]   on_lim;
  logic [N_DIGITS-1:0]      zab;
  logic                     run;
  logic [N_DIGITS-1:0][7:0] seg_d;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: return 7'h40;
      4'h1: return 7'h79;
      4'h2: return 7'h24;
      4'h3: return 7'h30;
      4'h4: return 7'h19;
      4'h5: return 7'h12;
      4'h6: return 7'h02;
      4'h7: return 7'h78;
      4'h8: return 7'h00;
      4'h9: return 7'h10;
      4'hA: return 7'h08;
      4'hB: return 7'h03;
      4'hC: return 7'h46;
      4'hD: return 7'h21;
      4'hE: return 7'h06;
      default: return 7'h0E;
    endcase
  endfunction

  assign tick     = (cnt == CNT_MAX);
  assign boundary = tick && (idx == IDX_MAX);
  assign in_s     = '{data: data, dp: dp, blink: blink_mask};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      idx        <= '0;
      frame_done <= 1'b0;
    end else begin
      cnt        <= tick ? '0 : cnt + 1'b1;
      frame_done <= boundary;
      if (tick) idx <= (idx == IDX_MAX) ? '0 : idx + 1'b1;
    end
  end

  // A load coinciding with the boundary is kept pending for the next frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_r <= '0;
      act_r  <= '0;
      pend   <= 1'b0;
    end else begin
      if (boundary && pend) act_r <= pend_r;
      if (load) begin
        pend_r <= in_s;
        pend   <= 1'b1;
      end else if (boundary) begin
        pend   <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fcnt  <= '0;
      phase <= 1'b0;
    end else if (boundary) begin
      if (fcnt == FR_MAX) begin
        fcnt  <= '0;
        phase <= ~phase;
      end else begin
        fcnt  <= fcnt + 1'b1;
      end
    end
  end

  // zab[i]: nibbles N_DIGITS-1..i are all zero.
  always_comb begin
    run = 1'b1;
    zab = '0;
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      run    = run & (act_r.data[4*i +: 4] == 4'h0);
      zab[i] = run;
    end
  end

  for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_dig
    logic [3:0] nib;
    logic       supp;
    assign nib  = act_r.data[4*gi +: 4];
    assign supp = lz_en && (gi != 0) && zab[gi];
    assign seg_d[gi] = (phase && act_r.blink[gi]) ? 8'hFF
                     : {~act_r.dp[gi], supp ? 7'h7F : hex7(nib)};
  end

  assign on_lim = 32'(brightness) * 32'(STEP);
  assign lit    = (&brightness) || (32'(cnt) < on_lim);

  // wei and duan share one register stage so a digit change never glitches.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sm_wei  <= '1;
      sm_duan <= 8'hFF;
    end else if (lit) begin
      sm_wei  <= ~(ONE << idx);
      sm_duan <= seg_d[idx];
    end else begin
      sm_wei  <= '1;
      sm_duan <= 8'hFF;
    end
  end

endmodule

// File: tb/tb_smg_scan_driver.sv
// Directed bench for smg_scan_driver: every cycle of each frame is checked against
// hand-computed segment patterns, with loads, blink, PWM and reset scenarios.
module tb_smg_scan_driver;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] data;
  logic [3:0]  dp, blink_mask;
  logic        lz_en;
  logic [1:0]  brightness;
  logic        load;
  logic [3:0]  sm_wei;
  logic [7:0]  sm_duan;
  logic        frame_done;

  int checks = 0;
  int errors = 0;
  int nb     = 0;

  smg_scan_driver #(.N_DIGITS(4), .CLK_DIV(16), .BR_W(2), .BLINK_FRAMES(2)) dut (
    .clk(clk), .rst(rst), .data(data), .dp(dp), .blink_mask(blink_mask),
    .lz_en(lz_en), .brightness(brightness), .load(load),
    .sm_wei(sm_wei), .sm_duan(sm_duan), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic sync_frame();
    int n = 0;
    while (frame_done !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    assert (n < 200) else begin
      errors++;
      $error("FAIL sync_timeout got %0d exp <200", n);
    end
    nb++;
  endtask

  // Starts on the negedge where frame_done is high and ends on the next one.
  // Digit k, slot clock c is visible 1+16k+c cycles after that negedge.
  task automatic check_frame(input string tag, input logic [3:0][7:0] ed,
                             input int on_clks, input logic [3:0] bm,
                             input int la, input logic [15:0] da,
                             input int lb, input logic [15:0] db);
    logic       ph, on, blk;
    logic [3:0] ew;
    logic [7:0] edn;
    int         k, c;
    ph = ((nb / 2) % 2) == 1;
    for (int i = 0; i < 64; i++) begin
      if (i == la) begin data = da; load = 1'b1; end
      else if (i == lb) begin data = db; load = 1'b1; end
      else load = 1'b0;
      @(negedge clk);
      k   = i / 16;
      c   = i % 16;
      on  = c < on_clks;
      blk = ph && bm[k];
      ew  = on ? ~(4'b0001 << k) : 4'hF;
      edn = on ? (blk ? 8'hFF : ed[k]) : 8'hFF;
      if (!blk) chk($sformatf("%s_wei_d%0d_c%0d", tag, k, c), {4'h0, sm_wei}, {4'h0, ew});
      chk($sformatf("%s_duan_d%0d_c%0d", tag, k, c), sm_duan, edn);
      chk($sformatf("%s_fd_%0d", tag, i), {7'h0, frame_done}, {7'h0, i == 63});
    end
    load = 1'b0;
    nb++;
  endtask

  initial begin
    rst = 1'b1; data = 16'h12AF; dp = 4'h0; blink_mask = 4'h0;
    lz_en = 1'b0; brightness = 2'd3; load = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_wei", {4'h0, sm_wei}, 8'h0F);
    chk("rst_duan", sm_duan, 8'hFF);
    chk("rst_fd", {7'h0, frame_done}, 8'h00);

    // 1: basic decode at full brightness
    rst = 1'b0; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    sync_frame();
    check_frame("t1", {8'hF9, 8'hA4, 8'h88, 8'h8E}, 16, 4'h0, -1, 16'h0, -1, 16'h0);

    // 2: leading-zero suppression
    lz_en = 1'b1;
    check_frame("t2a", {8'hF9, 8'hA4, 8'h88, 8'h8E}, 16, 4'h0, 0, 16'h0030, -1, 16'h0);
    check_frame("t2b", {8'hFF, 8'hFF, 8'hB0, 8'hC0}, 16, 4'h0, 0, 16'h0000, -1, 16'h0);
    check_frame("t2c", {8'hFF, 8'hFF, 8'hFF, 8'hC0}, 16, 4'h0, -1, 16'h0, -1, 16'h0);

    // 3: PWM brightness
    brightness = 2'd1;
    check_frame("t3a", {8'hFF, 8'hFF, 8'hFF, 8'hC0}, 4, 4'h0, -1, 16'h0, -1, 16'h0);
    brightness = 2'd2;
    check_frame("t3b", {8'hFF, 8'hFF, 8'hFF, 8'hC0}, 8, 4'h0, -1, 16'h0, -1, 16'h0);
    brightness = 2'd0;
    check_frame("t3c", {8'hFF, 8'hFF, 8'hFF, 8'hC0}, 0, 4'h0, -1, 16'h0, -1, 16'h0);
    brightness = 2'd3;
    lz_en = 1'b0;

    // 4: last load wins; load on the boundary cycle waits a frame
    check_frame("t4a", {8'hC0, 8'hC0, 8'hC0, 8'hC0}, 16, 4'h0, 10, 16'h1111, 40, 16'h2222);
    check_frame("t4b", {8'hA4, 8'hA4, 8'hA4, 8'hA4}, 16, 4'h0, 63, 16'h3333, -1, 16'h0);
    check_frame("t4c", {8'hA4, 8'hA4, 8'hA4, 8'hA4}, 16, 4'h0, -1, 16'h0, -1, 16'h0);
    check_frame("t4d", {8'hB0, 8'hB0, 8'hB0, 8'hB0}, 16, 4'h0, -1, 16'h0, -1, 16'h0);

    // 5: blink on digit 0 with its decimal point
    dp = 4'b0001; blink_mask = 4'b0001;
    check_frame("t5a", {8'hB0, 8'hB0, 8'hB0, 8'hB0}, 16, 4'h0, 0, 16'h3333, -1, 16'h0);
    for (int f = 0; f < 5; f++)
      check_frame($sformatf("t5b%0d", f), {8'hB0, 8'hB0, 8'hB0, 8'h30}, 16, 4'b0001,
                  -1, 16'h0, -1, 16'h0);

    // 6: asynchronous reset mid-slot drops the pending load
    repeat (20) @(negedge clk);
    data = 16'h4444; dp = 4'h0; blink_mask = 4'h0; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    chk("t6_pre_wei", {4'h0, sm_wei}, 8'h0D);
    rst = 1'b1;
    #1;
    chk("t6_async_wei", {4'h0, sm_wei}, 8'h0F);
    chk("t6_async_duan", sm_duan, 8'hFF);
    chk("t6_async_fd", {7'h0, frame_done}, 8'h00);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    nb = 0;
    check_frame("t6a", {8'hC0, 8'hC0, 8'hC0, 8'hC0}, 16, 4'h0, -1, 16'h0, -1, 16'h0);
    check_frame("t6b", {8'hC0, 8'hC0, 8'hC0, 8'hC0}, 16, 4'h0, -1, 16'h0, -1, 16'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
